regs_scoreboard: RTL and testbench
==================================

Name: regs_scoreboard

Overview:
Register-hazard scheduler that gates instruction issue out of the decode stage. It keeps a per-register count of in-flight writes, from issue to writeback retire, and allows issue only when all source registers are free and the destination counter has headroom. On an exception flush it drains the post-decode pipeline, then clears all state. It sits beside the decode stage's regfile/forwarding logic and drives an issue-ready/stall input into that stage.

Parameters:
N_REG, 32, number of architectural GPRs; register 0 is never tracked.
READ_PORTS, 2, source operands checked per issue.
CNT_WIDTH, 2, width of each pending counter; saturates at 2**CNT_WIDTH-1 outstanding writes.
DRAIN_CYCLES, 3, cycles spent in DRAIN after a flush; equals the stage depth from ID to WB.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  exception flush; kills younger instructions
issue_valid  in  1  decode stage presents an instruction
issue_raddr  in  READ_PORTS*5  source register addresses; port i is in bits [5i+4:5i]
issue_rvalid  in  READ_PORTS  per-source "operand used" mask
issue_we  in  1  instruction writes a GPR
issue_waddr  in  5  destination register
issue_ready  out  1  issue permitted this cycle (combinational)
wb_valid  in  1  one write retires at writeback
wb_waddr  in  5  retiring destination register
busy  out  N_REG  bit r = pending count of r is nonzero
draining  out  1  controller is in DRAIN

Behaviour:
- Reset (rst=1 at posedge): every counter is 0, state is RUN, drain counter is 0. busy=0, draining=0. issue_ready=0 while rst is high.
- States:
  - RUN: normal tracking.
  - DRAIN: issue blocked while older writers retire.
  - CLEAR: a one-cycle state that zeroes all counters.
- Transitions:
  - RUN --flush--> DRAIN, with the drain counter loaded to DRAIN_CYCLES-1.
  - DRAIN decrements the drain counter each cycle and goes to CLEAR when it reaches 0. A flush during DRAIN reloads the drain counter.
  - CLEAR --> RUN unconditionally. A flush in CLEAR goes to DRAIN.
- issue_ready = (state==RUN) && !flush && every source i with issue_rvalid[i]=1 and raddr_i!=0 is free && !(issue_we && issue_waddr!=0 && cnt[waddr] saturated).
  - A source is free when cnt==0, or when cnt==1 and wb_valid && wb_waddr==raddr_i in the same cycle (same-cycle release; data reaches the source through WB forwarding).
  - issue_ready does not depend on issue_valid.
- Issue fire = issue_valid && issue_ready. On fire with issue_we && waddr!=0, cnt[waddr] increments at the next edge.
- Retire: wb_valid && wb_waddr!=0 decrements cnt[wb_waddr]. This applies in RUN and DRAIN; retires are ignored in CLEAR. A retire against cnt==0 is ignored; the counter never wraps below 0.
- Fire and retire to the same register in the same cycle leave the count unchanged. Different registers update independently in that cycle.
- Writes to register 0 never change any counter. busy[0] is always 0.
- flush has priority over issue: a flush cycle never increments a counter. A retire in a flush cycle still decrements.
- rst has priority over flush and all updates.
- busy and draining are decoded from registered state. No output has a combinational path from issue_valid.

Optional Feature:
Macro SCOREBOARD_CHECK_EN.
- Defined: adds output port err (1 bit, reset 0). err is sticky and set on either:
  - a retire with cnt==0 while state==RUN;
  - an issue fire whose destination counter is already saturated (unreachable if issue_ready is correct).
  Only rst clears err. Simulation builds also emit a $error at the same events.
- Not defined: no err port, no check logic; underflowing retires are silently ignored.

Test Plan:
- RAW stall:
  - Issue we=1 waddr=5, then next cycle present rs=5 with rvalid=1 -> issue_ready=0 and busy[5]=1.
  - Then wb_valid, waddr=5 -> issue_ready=1 in that same cycle, and busy[5]=0 at the next edge.
- Saturation: with CNT_WIDTH=2, fire 3 writes to r7 with no retire -> cnt=3; a 4th issue with waddr=7 gives issue_ready=0. One retire to r7 -> issue_ready=1.
- Simultaneous issue and retire: cnt[9]=1, fire with waddr=9 and wb_waddr=9 in the same cycle -> cnt[9] stays 1 and busy[9] stays 1.
- Register 0: issue waddr=0 and sources raddr=0 with rvalid=1 -> issue_ready=1 and busy stays 0; wb_waddr=0 changes nothing.
- Flush/drain:
  - Pending r3 and r4, assert flush together with issue_valid -> no increment; draining=1 for 3 cycles and issue_ready=0.
  - A retire of r3 during DRAIN is applied.
  - Then one CLEAR cycle -> busy=0 and state returns to RUN. A second flush in the 2nd DRAIN cycle extends DRAIN to 3 more cycles.
- Check feature (SCOREBOARD_CHECK_EN): retire r12 with cnt=0 in RUN -> err=1, and err stays 1 until rst. Without the macro, the same stimulus gives no error and cnt[12]=0.

Source files
------------

// File: rtl/regs_scoreboard.sv
// Register-hazard scoreboard: per-GPR pending-write counters gating issue from decode,
// with a flush -> drain -> clear sequence. Optional `SCOREBOARD_CHECK_EN adds a sticky err port.
module regs_scoreboard #(
  parameter int unsigned N_REG        = 32,
  parameter int unsigned READ_PORTS   = 2,
  parameter int unsigned CNT_WIDTH    = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic [READ_PORTS*5-1:0] issue_raddr,
  input  logic [READ_PORTS-1:0]   issue_rvalid,
  input  logic                    issue_we,
  input  logic [4:0]              issue_waddr,
  output logic                    issue_ready,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_waddr,
  output logic [N_REG-1:0]        busy,
  output logic                    draining
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic                    err
`endif
);

  localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [DcW-1:0] DrainLoad = DcW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e               state_q, state_d;
  logic [DcW-1:0]       dcnt_q, dcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_REG];
  logic [CNT_WIDTH-1:0] cnt_d [N_REG];

  logic srcs_free;
  logic dst_full;
  logic dst_block;
  logic fire;
  logic retire_en;

  // A source is free if idle, or if its last pending write retires this very cycle.
  always_comb begin
    srcs_free = 1'b1;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (issue_rvalid[p] && issue_raddr[5*p +: 5] != 5'd0) begin
        for (int r = 1; r < N_REG; r++) begin
          if (issue_raddr[5*p +: 5] == 5'(r)) begin
            if (!((cnt_q[r] == '0) ||
                  (cnt_q[r] == CntOne && wb_valid && wb_waddr == 5'(r)))) begin
              srcs_free = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    dst_full = 1'b0;
    for (int r = 1; r < N_REG; r++) begin
      if (issue_waddr == 5'(r) && cnt_q[r] == CntMax) dst_full = 1'b1;
    end
  end

  assign dst_block   = issue_we && (issue_waddr != 5'd0) && dst_full;
  assign issue_ready = !rst && (state_q == StRun) && !flush && srcs_free && !dst_block;
  assign fire        = issue_valid && issue_ready;
  assign retire_en   = wb_valid && (wb_waddr != 5'd0) && (state_q != StClear);

  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0 || state_q == StClear) begin
        cnt_d[r] = '0;
      end else begin
        // Same-register fire and retire cancel out.
        if (fire && issue_we && issue_waddr == 5'(r)) begin
          if (!(retire_en && wb_waddr == 5'(r) && cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] + CntOne;
        end else if (retire_en && wb_waddr == 5'(r) && cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StDrain;
          dcnt_d  = DrainLoad;
        end
      end
      StDrain: begin
        if (flush) begin
          dcnt_d = DrainLoad;
        end else if (dcnt_q == '0) begin
          state_d = StClear;
        end else begin
          dcnt_d = dcnt_q - DcW'(1);
        end
      end
      StClear: begin
        if (flush) begin
          state_d = StDrain;
          dcnt_d  = DrainLoad;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      dcnt_q  <= '0;
      for (int r = 0; r < N_REG; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      for (int r = 0; r < N_REG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < N_REG; r++) busy[r] = (cnt_q[r] != '0);
  end

  assign draining = (state_q == StDrain);

`ifdef SCOREBOARD_CHECK_EN
  logic wb_cnt_zero;
  logic underflow;
  logic sat_fire;

  always_comb begin
    wb_cnt_zero = 1'b0;
    for (int r = 1; r < N_REG; r++) begin
      if (wb_waddr == 5'(r) && cnt_q[r] == '0) wb_cnt_zero = 1'b1;
    end
  end

  assign underflow = wb_valid && (wb_waddr != 5'd0) && (state_q == StRun) && wb_cnt_zero;
  assign sat_fire  = fire && dst_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (underflow || sat_fire) begin
      err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && underflow) $error("regs_scoreboard: retire of r%0d with no pending write", wb_waddr);
    if (!rst && sat_fire)  $error("regs_scoreboard: issue to saturated r%0d", issue_waddr);
  end
`endif
`endif

endmodule

// File: tb/tb_regs_scoreboard.sv
// Scoreboard bench for regs_scoreboard: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_regs_scoreboard;

  localparam int SelRdy  = 0;
  localparam int SelBusy = 1;
  localparam int SelDrn  = 2;
  localparam int SelErr  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic [9:0]  issue_raddr;
  logic [1:0]  issue_rvalid;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] busy;
  logic        draining;
`ifdef SCOREBOARD_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  regs_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_raddr  (issue_raddr),
    .issue_rvalid (issue_rvalid),
    .issue_we     (issue_we),
    .issue_waddr  (issue_waddr),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_waddr     (wb_waddr),
    .busy         (busy),
    .draining     (draining)
`ifdef SCOREBOARD_CHECK_EN
    ,
    .err          (err)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_cyc[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SelRdy:  return {31'd0, issue_ready};
      SelBusy: return busy;
      SelDrn:  return {31'd0, draining};
`ifdef SCOREBOARD_CHECK_EN
      SelErr:  return {31'd0, err};
`endif
      default: return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int          c;
      int          s;
      logic [31:0] e;
      logic [31:0] a;
      string       n;
      c = q_cyc.pop_front();
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      a = sample(s);
      checks++;
      if (c != cyc || a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d, queued for %0d)", n, a, e, cyc, c);
      end
    end
  end

  task automatic exp_out(input int sel, input logic [31:0] v, input string n);
    q_cyc.push_back(cyc);
    q_sel.push_back(sel);
    q_exp.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_raddr  = '0;
    issue_rvalid = '0;
    issue_we     = 1'b0;
    issue_waddr  = '0;
    wb_valid     = 1'b0;
    wb_waddr     = '0;
  endtask

  task automatic issue(input logic v, input logic we, input logic [4:0] wa);
    issue_valid = v;
    issue_we    = we;
    issue_waddr = wa;
  endtask

  task automatic src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] rv);
    issue_raddr  = {a1, a0};
    issue_rvalid = rv;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    wb_valid = v;
    wb_waddr = a;
  endtask

  initial begin
    rst = 1'b1;
    nxt();
    nxt();
    exp_out(SelRdy, 0, "rst_ready");
    exp_out(SelBusy, 0, "rst_busy");
    exp_out(SelDrn, 0, "rst_draining");

    // RAW hazard on r5, operand on read port 1
    nxt(); rst = 1'b0; issue(1, 1, 5);
    exp_out(SelRdy, 1, "raw_first_issue");
    nxt(); issue(1, 0, 0); src(0, 5, 2'b10);
    exp_out(SelRdy, 0, "raw_stall");
    exp_out(SelBusy, 32'h0000_0020, "raw_busy");
    nxt(); src(0, 5, 2'b00);
    exp_out(SelRdy, 1, "raw_masked_src");
    nxt(); issue(1, 0, 0); src(0, 5, 2'b10); wb(1, 5);
    exp_out(SelRdy, 1, "raw_same_cycle_release");
    nxt();
    exp_out(SelBusy, 0, "raw_retired");

    // Saturation of r7
    for (int i = 0; i < 3; i++) begin
      nxt(); issue(1, 1, 7);
      exp_out(SelRdy, 1, "sat_fire");
    end
    nxt(); issue(1, 1, 7);
    exp_out(SelRdy, 0, "sat_block");
    exp_out(SelBusy, 32'h0000_0080, "sat_busy");
    nxt(); issue(0, 1, 7); wb(1, 7);
    exp_out(SelRdy, 0, "sat_retire_cycle");
    nxt(); issue(1, 1, 7);
    exp_out(SelRdy, 1, "sat_headroom");
    for (int i = 0; i < 3; i++) begin
      nxt(); wb(1, 7);
    end
    nxt();
    exp_out(SelBusy, 0, "sat_drained");

    // Simultaneous fire and retire on r9
    nxt(); issue(1, 1, 9);
    exp_out(SelRdy, 1, "sim_first");
    nxt(); issue(1, 1, 9); wb(1, 9);
    exp_out(SelRdy, 1, "sim_ready");
    exp_out(SelBusy, 32'h0000_0200, "sim_busy");
    nxt();
    exp_out(SelBusy, 32'h0000_0200, "sim_hold");
    nxt(); wb(1, 9);
    nxt();
    exp_out(SelBusy, 0, "sim_clear");

    // Register 0 is never tracked
    nxt(); issue(1, 1, 0); src(0, 0, 2'b11);
    exp_out(SelRdy, 1, "r0_ready");
    nxt(); wb(1, 0);
    exp_out(SelBusy, 0, "r0_busy");
    nxt();
    exp_out(SelBusy, 0, "r0_wb_busy");

    // Flush with pending r3, r4; retire r3 during drain
    nxt(); issue(1, 1, 3);
    exp_out(SelRdy, 1, "fl_issue3");
    nxt(); issue(1, 1, 4);
    exp_out(SelRdy, 1, "fl_issue4");
    nxt(); flush = 1'b1; issue(1, 1, 3);
    exp_out(SelRdy, 0, "fl_ready");
    exp_out(SelBusy, 32'h0000_0018, "fl_busy");
    nxt(); wb(1, 3);
    exp_out(SelDrn, 1, "drain_1");
    exp_out(SelRdy, 0, "drain_ready");
    nxt();
    exp_out(SelDrn, 1, "drain_2");
    exp_out(SelBusy, 32'h0000_0010, "drain_retire_applied");
    nxt();
    exp_out(SelDrn, 1, "drain_3");
    nxt();
    exp_out(SelDrn, 0, "clear_draining");
    exp_out(SelRdy, 0, "clear_ready");
    exp_out(SelBusy, 32'h0000_0010, "clear_busy");
    nxt();
    exp_out(SelBusy, 0, "run_busy");
    exp_out(SelRdy, 1, "run_ready");
    exp_out(SelDrn, 0, "run_draining");

    // Re-flush in the second drain cycle extends drain
    nxt(); issue(1, 1, 4);
    exp_out(SelRdy, 1, "rf_issue4");
    nxt(); flush = 1'b1;
    nxt();
    exp_out(SelDrn, 1, "rf_drain_1");
    nxt(); flush = 1'b1;
    exp_out(SelDrn, 1, "rf_drain_2");
    for (int i = 0; i < 3; i++) begin
      nxt();
      exp_out(SelDrn, 1, "rf_extended");
    end
    nxt();
    exp_out(SelDrn, 0, "rf_clear_draining");
    exp_out(SelBusy, 32'h0000_0010, "rf_clear_busy");
    nxt();
    exp_out(SelBusy, 0, "rf_run_busy");
    exp_out(SelDrn, 0, "rf_run_draining");

    // Underflowing retire of r12
    nxt(); wb(1, 12);
`ifdef SCOREBOARD_CHECK_EN
    exp_out(SelErr, 0, "err_before");
`endif
    nxt(); src(12, 0, 2'b01);
    exp_out(SelBusy, 0, "uflow_busy");
    exp_out(SelRdy, 1, "uflow_ready");
`ifdef SCOREBOARD_CHECK_EN
    exp_out(SelErr, 1, "err_set");
`endif
    nxt();
    nxt();
`ifdef SCOREBOARD_CHECK_EN
    exp_out(SelErr, 1, "err_sticky");
`endif
    exp_out(SelBusy, 0, "final_busy");

    nxt();
    @(negedge clk);
    #1;
    checks++;
    if (q_cyc.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: got %0d entries expected 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
